// File: rtl/eq_pkg.sv
`default_nettype none
// ============================================================================
// eq_pkg : widths, slot bounds and sample type shared by the codec interface
// Rev 1.0
// ============================================================================
package eq_pkg;
  localparam int CNT_W      = 10;
  localparam int SAMPLE_W   = 16;
  localparam int FIRST_SLOT = 1;
  localparam int LAST_SLOT  = 16;
  localparam int SLOT_W     = 5;
  localparam int POS_W      = CNT_W - 4;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  function automatic logic slot_active(input logic [SLOT_W-1:0] slot);
    return (slot >= SLOT_W'(FIRST_SLOT)) && (slot <= SLOT_W'(LAST_SLOT));
  endfunction

  // Slot 1 carries bit 15 (MSB), slot 16 carries bit 0.
  function automatic logic [3:0] slot_bit(input logic [SLOT_W-1:0] slot);
    return 4'(SLOT_W'(LAST_SLOT) - slot);
  endfunction
endpackage
`default_nettype wire

// File: rtl/codec_intf_if.sv
`default_nettype none
// ============================================================================
// codec_intf_if : sample and serial codec bus of codec_intf
// Rev 1.0
// ============================================================================
interface codec_intf_if;
  import eq_pkg::*;

  sample_t lft_out;
  sample_t rht_out;
  sample_t lft_in;
  sample_t rht_in;
  logic    SDout;
  logic    MCLK;
  logic    SCLK;
  logic    LRCLK;
  logic    SDin;
  logic    RSTn;
  logic    valid;

  modport master (
    input  lft_out, rht_out, SDout,
    output MCLK, SCLK, LRCLK, SDin, RSTn, lft_in, rht_in, valid
  );

  modport slave (
    output lft_out, rht_out, SDout,
    input  MCLK, SCLK, LRCLK, SDin, RSTn, lft_in, rht_in, valid
  );
endinterface
`default_nettype wire

// File: rtl/codec_clk_gen.sv
`default_nettype none
// ============================================================================
// codec_clk_gen : free-running frame counter, codec clocks and bit strobes
// Rev 1.0
// ============================================================================
module codec_clk_gen
  import eq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  output logic [POS_W-1:0] pos,
  output logic             MCLK,
  output logic             SCLK,
  output logic             LRCLK,
  output logic             sclk_rise,
  output logic             sclk_fall,
  output logic             frame_end
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // pos = {channel, slot}; strobes flag the edge on which cnt leaves the value.
  assign pos       = cnt_q[CNT_W-1:4];
  assign MCLK      = cnt_q[1];
  assign SCLK      = cnt_q[3];
  assign LRCLK     = cnt_q[CNT_W-1];
  assign sclk_rise = (cnt_q[3:0] == 4'b0111);
  assign sclk_fall = (cnt_q[3:0] == 4'b1111);
  assign frame_end = &cnt_q;

endmodule
`default_nettype wire

// File: rtl/codec_intf.sv
`default_nettype none
// ============================================================================
// codec_intf : I2S-style serial link to a stereo codec, 16-bit samples
// Option macro CODEC_LOOPBACK_EN : transmit the just-received samples
// Rev 1.0
// ============================================================================
module codec_intf
  import eq_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  codec_intf_if.master bus
);

  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] tx_pos;
  logic             sclk_rise;
  logic             sclk_fall;
  logic             frame_end;
  logic             mclk;
  logic             sclk;
  logic             lrclk;

  codec_clk_gen u_clk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .pos       (pos),
    .MCLK      (mclk),
    .SCLK      (sclk),
    .LRCLK     (lrclk),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .frame_end (frame_end)
  );

  sample_t lft_sr_q,  lft_sr_d;
  sample_t rht_sr_q,  rht_sr_d;
  sample_t lft_in_q,  lft_in_d;
  sample_t rht_in_q,  rht_in_d;
  sample_t lft_buf_q, lft_buf_d;
  sample_t rht_buf_q, rht_buf_d;
  logic    sdin_q,    sdin_d;
  logic    valid_q,   valid_d;
  logic    rstn_q,    rstn_d;

  // SDin changes on the SCLK fall that opens the next slot.
  assign tx_pos = pos + POS_W'(1);

  always_comb begin
    lft_sr_d  = lft_sr_q;
    rht_sr_d  = rht_sr_q;
    lft_in_d  = lft_in_q;
    rht_in_d  = rht_in_q;
    lft_buf_d = lft_buf_q;
    rht_buf_d = rht_buf_q;
    sdin_d    = sdin_q;
    valid_d   = frame_end;
    rstn_d    = 1'b1;

    if (sclk_rise && slot_active(pos[SLOT_W-1:0])) begin
      if (pos[POS_W-1]) begin
        rht_sr_d = {rht_sr_q[SAMPLE_W-2:0], bus.SDout};
      end else begin
        lft_sr_d = {lft_sr_q[SAMPLE_W-2:0], bus.SDout};
      end
    end

    if (sclk_fall) begin
      sdin_d = 1'b0;
      if (slot_active(tx_pos[SLOT_W-1:0])) begin
        sdin_d = tx_pos[POS_W-1] ? rht_buf_q[slot_bit(tx_pos[SLOT_W-1:0])]
                                 : lft_buf_q[slot_bit(tx_pos[SLOT_W-1:0])];
      end
    end

    if (frame_end) begin
      lft_in_d = lft_sr_q;
      rht_in_d = rht_sr_q;
`ifdef CODEC_LOOPBACK_EN
      lft_buf_d = lft_sr_q;
      rht_buf_d = rht_sr_q;
`else
      lft_buf_d = bus.lft_out;
      rht_buf_d = bus.rht_out;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lft_sr_q  <= '0;
      rht_sr_q  <= '0;
      lft_in_q  <= '0;
      rht_in_q  <= '0;
      lft_buf_q <= '0;
      rht_buf_q <= '0;
      sdin_q    <= 1'b0;
      valid_q   <= 1'b0;
      rstn_q    <= 1'b0;
    end else begin
      lft_sr_q  <= lft_sr_d;
      rht_sr_q  <= rht_sr_d;
      lft_in_q  <= lft_in_d;
      rht_in_q  <= rht_in_d;
      lft_buf_q <= lft_buf_d;
      rht_buf_q <= rht_buf_d;
      sdin_q    <= sdin_d;
      valid_q   <= valid_d;
      rstn_q    <= rstn_d;
    end
  end

  assign bus.MCLK   = mclk;
  assign bus.SCLK   = sclk;
  assign bus.LRCLK  = lrclk;
  assign bus.SDin   = sdin_q;
  assign bus.RSTn   = rstn_q;
  assign bus.lft_in = lft_in_q;
  assign bus.rht_in = rht_in_q;
  assign bus.valid  = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_codec_intf.sv
`default_nettype none
// ============================================================================
// tb_codec_intf : codec model + scoreboards for codec_intf
// Rev 1.0
// ============================================================================
module tb_codec_intf;
  import eq_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #10 clk = ~clk;

  codec_intf_if bus ();

  codec_intf dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam int NF = 8;
  // Frame 4 is aborted by a mid-frame reset.
  logic [15:0] cod_l [NF] = '{16'h7FFF, 16'h0F0F, 16'h5A82, 16'h0001,
                              16'h5555, 16'h1234, 16'h7FFF, 16'h0000};
  logic [15:0] cod_r [NF] = '{16'h8000, 16'hF0F0, 16'hA57E, 16'hFFFF,
                              16'hAAAA, 16'hEDCC, 16'h8000, 16'h7F00};
  logic [15:0] out_l [NF] = '{16'h1234, 16'h8001, 16'h0000, 16'h5555,
                              16'h6666, 16'h0F0F, 16'hFFFF, 16'hABCD};
  logic [15:0] out_r [NF] = '{16'hA5A5, 16'h7FFE, 16'hFFFF, 16'hAAAA,
                              16'h9999, 16'h3C3C, 16'h0000, 16'h0123};

  logic [31:0] rx_q [$];
  logic [31:0] tx_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: scoreboard event with no expectation at %0t", name, $time);
  endtask

  // ---------------- codec model: ADC drive + DAC capture ----------------
  int          mf = 0;
  int          slot = 0;
  int          nz = 0;
  logic        prev_lr = 1'b0, prev_sclk = 1'b0, prev_rstn = 1'b0;
  logic [15:0] dac_l = '0, dac_r = '0, word;
  logic [31:0] tx_exp;

  always @(negedge clk) begin
    if (bus.RSTn !== 1'b1) begin
      if (prev_rstn) mf++;
      slot = 0; nz = 0; dac_l = '0; dac_r = '0;
      prev_lr = 1'b0; prev_sclk = 1'b0;
      bus.SDout = 1'b0;
    end else begin
      if (bus.LRCLK != prev_lr) begin
        slot = 0;
        if (prev_lr && !bus.LRCLK) begin
          if (tx_q.size() == 0) fail_now("tx_queue_underflow");
          else begin
            tx_exp = tx_q.pop_front();
            chk("tx_left", {16'h0, dac_l}, {16'h0, tx_exp[31:16]});
            chk("tx_right", {16'h0, dac_r}, {16'h0, tx_exp[15:0]});
          end
          chk("tx_idle_slots_zero", nz, 0);
          dac_l = '0; dac_r = '0; nz = 0;
          mf++;
        end
      end else if (prev_sclk && !bus.SCLK) begin
        slot++;
      end
      if (!prev_sclk && bus.SCLK) begin
        if (slot >= 1 && slot <= 16) begin
          if (bus.LRCLK) dac_r = {dac_r[14:0], bus.SDin};
          else           dac_l = {dac_l[14:0], bus.SDin};
        end else if (bus.SDin !== 1'b0) begin
          nz++;
        end
      end
      word = bus.LRCLK ? cod_r[(mf < NF) ? mf : 0] : cod_l[(mf < NF) ? mf : 0];
      bus.SDout = (slot >= 1 && slot <= 16) ? word[16 - slot] : 1'b0;
      prev_lr   = bus.LRCLK;
      prev_sclk = bus.SCLK;
    end
    prev_rstn = bus.RSTn;
  end

  // ---------------- receive monitor + valid spacing ----------------
  int          since = 0;
  logic [31:0] rx_exp;

  always @(negedge clk) begin
    if (bus.RSTn !== 1'b1) begin
      since = 0;
    end else begin
      since++;
      if (bus.valid === 1'b1) begin
        chk("valid_spacing", since, 1024);
        if (rx_q.size() == 0) fail_now("rx_queue_underflow");
        else begin
          rx_exp = rx_q.pop_front();
          chk("rx_left", {16'h0, $unsigned(bus.lft_in)}, {16'h0, rx_exp[31:16]});
          chk("rx_right", {16'h0, $unsigned(bus.rht_in)}, {16'h0, rx_exp[15:0]});
        end
        since = 0;
      end else if (since > 1100) begin
        checks++;
        failures++;
        $display("FAIL valid_timeout: got no valid in %0d clks expected 1024", since);
        since = 0;
      end
    end
  end

  // ---------------- codec clock period monitor ----------------
  int   cyc = 0;
  int   last_lr = -1, last_sc = -1, last_mc = -1;
  logic p_lr = 1'b0, p_sc = 1'b0, p_mc = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.RSTn !== 1'b1) begin
      last_lr = -1; last_sc = -1; last_mc = -1;
    end else begin
      if (bus.LRCLK && !p_lr) begin
        if (last_lr >= 0) chk("lrclk_period", cyc - last_lr, 1024);
        last_lr = cyc;
      end
      if (bus.SCLK && !p_sc) begin
        if (last_sc >= 0) chk("sclk_period", cyc - last_sc, 16);
        last_sc = cyc;
      end
      if (bus.MCLK && !p_mc) begin
        if (last_mc >= 0) chk("mclk_period", cyc - last_mc, 4);
        last_mc = cyc;
      end
    end
    p_lr = bus.LRCLK; p_sc = bus.SCLK; p_mc = bus.MCLK;
  end

  // ---------------- stimulus ----------------
  task automatic reset_checks();
    chk("rst_MCLK",   {31'h0, bus.MCLK},  0);
    chk("rst_SCLK",   {31'h0, bus.SCLK},  0);
    chk("rst_LRCLK",  {31'h0, bus.LRCLK}, 0);
    chk("rst_SDin",   {31'h0, bus.SDin},  0);
    chk("rst_RSTn",   {31'h0, bus.RSTn},  0);
    chk("rst_valid",  {31'h0, bus.valid}, 0);
    chk("rst_lft_in", {16'h0, $unsigned(bus.lft_in)}, 0);
    chk("rst_rht_in", {16'h0, $unsigned(bus.rht_in)}, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    chk("RSTn_before_release", {31'h0, bus.RSTn}, 0);
    @(posedge clk);
    #1;
    chk("RSTn_after_release", {31'h0, bus.RSTn}, 1);
  endtask

  // Entered with cnt=1; disturbs the inputs early, sets the real sample at
  // cnt=0x200 and returns with cnt=1 of the next frame.
  task automatic run_frame(input int f);
    repeat (199) @(posedge clk);
    @(negedge clk);
    bus.lft_out = 16'hDEAD;
    bus.rht_out = 16'hBEEF;
    repeat (312) @(posedge clk);
    @(negedge clk);
    bus.lft_out = out_l[f];
    bus.rht_out = out_r[f];
    repeat (513) @(posedge clk);
  endtask

  initial begin
    bus.lft_out = '0;
    bus.rht_out = '0;
    for (int f = 0; f < NF; f++) begin
      if (f != 4) begin
        rx_q.push_back({cod_l[f], cod_r[f]});
        if (f == 0 || f == 5) tx_q.push_back(32'h0);
`ifdef CODEC_LOOPBACK_EN
        else tx_q.push_back({cod_l[f-1], cod_r[f-1]});
`else
        else tx_q.push_back({out_l[f-1], out_r[f-1]});
`endif
      end
    end

    repeat (5) @(posedge clk);
    #1;
    reset_checks();
    release_reset();

    for (int f = 0; f < 4; f++) run_frame(f);

    repeat (511) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      reset_checks();
    end
    release_reset();

    for (int f = 5; f < NF; f++) run_frame(f);

    repeat (20) @(posedge clk);
    chk("rx_queue_drained", rx_q.size(), 0);
    chk("tx_queue_drained", tx_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
